bwt_frame_tx: RTL and testbench

//  Downstream stage of the BWT sorter. When the sorter pulses done, this block latches the BWT

---
 rtl/bwt_frame_tx.sv | 109 ++++++++++
 tb/tb_bwt_frame_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bwt_frame_tx.sv
// bwt_frame_tx: latches a sorted BWT block on bwt_done, finds the zero-suffix row, streams header+STRING_LEN bytes on m_data/m_valid/m_ready/m_last; busy/no_primary/overrun status
module bwt_frame_tx #(
  parameter int STRING_LEN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bwt_done,
  input  logic [8*STRING_LEN-1:0] bwt_string,
  input  logic [8*STRING_LEN-1:0] bwt_suffixes,
  output logic [7:0]              m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    no_primary,
  output logic                    overrun
);
  typedef enum logic [1:0] {IDLE, SCAN, HDR, DATA} state_t;
  localparam logic [7:0] LAST = 8'(STRING_LEN - 1);
  state_t state, state_n;
  logic [8*STRING_LEN-1:0] buf_str, buf_suf;
  logic [7:0] idx, idx_n, nxt, primary, primary_n, m_data_n, cur_suf, hdr;
  logic found, found_n, m_valid_n, m_last_n, no_primary_n, load, hit, hs;
  assign nxt = idx + 8'd1;
  assign cur_suf = buf_suf[int'(idx)*8 +: 8];
  assign hit = (cur_suf == 8'd0) && !found;
  assign hdr = found ? primary : hit ? idx : 8'hFF;
  assign hs = m_valid && m_ready;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    idx_n = idx;
    primary_n = primary;
    found_n = found;
    m_data_n = m_data;
    m_valid_n = m_valid;
    m_last_n = m_last;
    no_primary_n = no_primary;
    load = 1'b0;
    case (state)
      IDLE: if (bwt_done) begin
        load = 1'b1;
        no_primary_n = 1'b0;
        found_n = 1'b0;
        idx_n = 8'd0;
        state_n = SCAN;
      end
      SCAN: begin
        primary_n = hdr;
        found_n = found || hit;
        idx_n = nxt;
        if (idx == LAST) begin
          state_n = HDR;
          m_valid_n = 1'b1;
          m_last_n = 1'b0;
          m_data_n = hdr;
          no_primary_n = !(found || hit);
        end
      end
      HDR: if (hs) begin
        idx_n = 8'd0;
        m_data_n = buf_str[7:0];
        m_last_n = LAST == 8'd0;
        state_n = DATA;
      end
      DATA: if (hs) begin
        if (m_last) begin
          m_valid_n = 1'b0;
          m_last_n = 1'b0;
          state_n = IDLE;
        end else begin
          idx_n = nxt;
          m_data_n = buf_str[int'(nxt)*8 +: 8];
          m_last_n = nxt == LAST;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      primary <= '0;
      found <= 1'b0;
      m_data <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      no_primary <= 1'b0;
      overrun <= 1'b0;
      buf_str <= '0;
      buf_suf <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      primary <= primary_n;
      found <= found_n;
      m_data <= m_data_n;
      m_valid <= m_valid_n;
      m_last <= m_last_n;
      no_primary <= no_primary_n;
      overrun <= overrun || (bwt_done && busy);
      if (load) begin
        buf_str <= bwt_string;
        buf_suf <= bwt_suffixes;
      end
    end
  end
endmodule

// File: tb/tb_bwt_frame_tx.sv
// tb_bwt_frame_tx: directed checks of bwt_frame_tx with STRING_LEN=4
module tb_bwt_frame_tx;
  localparam int L = 4;
  logic clk = 1'b0, rst = 1'b1, bwt_done = 1'b0, m_ready = 1'b0;
  logic [8*L-1:0] bwt_string = '0, bwt_suffixes = '0;
  logic [7:0] m_data;
  logic m_valid, m_last, busy, no_primary, overrun;
  int total = 0, bad = 0;
  bwt_frame_tx #(.STRING_LEN(L)) dut (
    .clk(clk), .rst(rst), .bwt_done(bwt_done), .bwt_string(bwt_string),
    .bwt_suffixes(bwt_suffixes), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .no_primary(no_primary),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] pack4(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic send_done;
    bwt_done = 1'b1;
    step;
    bwt_done = 1'b0;
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_data"}, 32'(m_data), 0);
    chk({tag, "_last"}, 32'(m_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_no_primary"}, 32'(no_primary), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask
  task automatic run_frame(input logic [7:0] e0, e1, e2, e3, e4, input bit toggle,
                           input bit np, input int done_at);
    logic [7:0] exp [5];
    logic [3:0] pat = 4'b1001;
    int cyc = 1, k = 0, t = 0;
    bit pulsed = 1'b0;
    exp = '{e0, e1, e2, e3, e4};
    m_ready = 1'b0;
    chk("busy_scan", 32'(busy), 1);
    while (!m_valid && cyc < 40) begin
      step;
      cyc++;
    end
    chk("latency", cyc, 5);
    while (k < 5 && t < 60) begin
      m_ready = toggle ? pat[t%4] : 1'b1;
      chk("valid", 32'(m_valid), 1);
      chk("data", 32'(m_data), 32'(exp[k]));
      chk("last", 32'(m_last), 32'(k == 4));
      chk("no_primary", 32'(no_primary), 32'(np));
      if (k == done_at && !pulsed) begin
        bwt_done = 1'b1;
        pulsed = 1'b1;
      end
      if (m_ready) k++;
      t++;
      step;
      bwt_done = 1'b0;
    end
    chk("frame_len", k, 5);
    m_ready = 1'b0;
    chk("valid_end", 32'(m_valid), 0);
    chk("busy_end", 32'(busy), 0);
  endtask
  initial begin
    int w;
    step;
    step;
    chk_idle_outputs("reset");
    rst = 1'b0;
    bwt_string = pack4("c", "a", "b", "a");
    bwt_suffixes = pack4(3, 0, 1, 2);
    send_done;
    run_frame(8'h01, 8'h63, 8'h61, 8'h62, 8'h61, 1'b0, 1'b0, -1);
    chk("overrun_f1", 32'(overrun), 0);
    send_done;
    run_frame(8'h01, 8'h63, 8'h61, 8'h62, 8'h61, 1'b1, 1'b0, -1);
    bwt_suffixes = pack4(1, 2, 3, 1);
    send_done;
    run_frame(8'hFF, 8'h63, 8'h61, 8'h62, 8'h61, 1'b0, 1'b1, -1);
    bwt_suffixes = pack4(3, 0, 1, 2);
    send_done;
    run_frame(8'h01, 8'h63, 8'h61, 8'h62, 8'h61, 1'b0, 1'b0, -1);
    bwt_string = pack4("w", "x", "y", "z");
    bwt_suffixes = pack4(0, 3, 1, 2);
    send_done;
    run_frame(8'h00, 8'h77, 8'h78, 8'h79, 8'h7A, 1'b0, 1'b0, -1);
    chk("overrun_b2b", 32'(overrun), 0);
    bwt_string = pack4("c", "a", "b", "a");
    bwt_suffixes = pack4(3, 0, 1, 2);
    send_done;
    bwt_string = pack4(8'h11, 8'h22, 8'h33, 8'h44);
    bwt_suffixes = pack4(5, 6, 0, 7);
    run_frame(8'h01, 8'h63, 8'h61, 8'h62, 8'h61, 1'b0, 1'b0, 2);
    chk("overrun_set", 32'(overrun), 1);
    m_ready = 1'b1;
    repeat (10) step;
    chk("no_second_frame", 32'(m_valid), 0);
    chk("busy_after_drop", 32'(busy), 0);
    chk("overrun_sticky", 32'(overrun), 1);
    m_ready = 1'b0;
    bwt_string = pack4("c", "a", "b", "a");
    bwt_suffixes = pack4(3, 0, 1, 2);
    send_done;
    w = 0;
    while (!m_valid && w < 40) begin
      step;
      w++;
    end
    chk("rst_wait", 32'(m_valid), 1);
    m_ready = 1'b1;
    step;
    m_ready = 1'b0;
    step;
    chk("stall_valid", 32'(m_valid), 1);
    chk("stall_data", 32'(m_data), 32'h63);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk_idle_outputs("mid_rst");
    m_ready = 1'b1;
    repeat (8) step;
    chk("post_rst_quiet", 32'(m_valid), 0);
    send_done;
    run_frame(8'h01, 8'h63, 8'h61, 8'h62, 8'h61, 1'b0, 1'b0, -1);
    chk("overrun_after_rst", 32'(overrun), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
